// File: rtl/hexraster_pkg.sv
// Shared constants, scaling helper and the per-beat configuration record
// for the hex-to-screen raster front end.
package hexraster_pkg;

    // Width of the fixed-point fields in hex_cfg_t; the top's VAL_W must match.
    localparam int HEX_VAL_W = 32;

    // Lattice constants in Q16: sqrt(3)/2 and 3/2.
    localparam logic [31:0] K_SQRT3_HALF_Q16 = 32'd56756;
    localparam logic [31:0] K_THREE_HALF_Q16 = 32'd98304;

    // Re-express a Q16 constant with `frac` fractional bits.
    function automatic logic [31:0] k_scale(input logic [31:0] k16, input int frac);
        if (frac >= 16)
            return k16 << (frac - 16);
        else
            return k16 >> (16 - frac);
    endfunction

    // Configuration sampled with a beat and carried alongside it.
    typedef struct packed {
        logic                        pointy;
        logic signed [HEX_VAL_W-1:0] size;
        logic signed [HEX_VAL_W-1:0] cam_x;
        logic signed [HEX_VAL_W-1:0] cam_y;
        logic signed [HEX_VAL_W-1:0] zoom;
        logic [15:0]                 view_w;
        logic [15:0]                 view_h;
    } hex_cfg_t;

endpackage

// File: rtl/hex_lane_xform.sv
// One lane of the hex-to-screen transform: axial combine, lattice scale,
// camera/zoom with saturation and viewport culling. Three register stages,
// all advanced by the shared adv enable.
module hex_lane_xform
    import hexraster_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int VAL_W   = 32,
    parameter int FRAC    = 16
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     adv,
    input  logic                     pointy_s0,
    input  logic signed [COORD_W-1:0] q,
    input  logic signed [COORD_W-1:0] r,
    input  logic                     mask,
    input  logic                     pointy_s1,
    input  logic signed [VAL_W-1:0]  size_s1,
    input  logic signed [VAL_W-1:0]  cam_x_s2,
    input  logic signed [VAL_W-1:0]  cam_y_s2,
    input  logic signed [VAL_W-1:0]  zoom_s2,
    input  logic [15:0]              view_w_s2,
    input  logic [15:0]              view_h_s2,
    output logic signed [VAL_W-1:0]  x,
    output logic signed [VAL_W-1:0]  y,
    output logic                     vis,
    output logic                     sat
);

    // a/b need two extra bits: |2q + r| <= 3 * 2^(COORD_W-1).
    localparam int AW = COORD_W + 2;
    // a * k * size with k held as a non-negative 33-bit value; never wraps.
    localparam int PW = AW + 33 + VAL_W;
    // hx - cam, one extra bit for the subtraction.
    localparam int DW = PW + 1;
    // (hx - cam) * zoom.
    localparam int MW = DW + VAL_W;

    localparam logic [31:0] KA = k_scale(K_SQRT3_HALF_Q16, FRAC);
    localparam logic [31:0] KB = k_scale(K_THREE_HALF_Q16, FRAC);

    localparam logic signed [VAL_W-1:0] VMAX = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic signed [VAL_W-1:0] VMIN = {1'b1, {(VAL_W-1){1'b0}}};

    // ---------------- stage 1: axial combine ----------------
    logic signed [AW-1:0] q_e, r_e, a_d, b_d, a_s1, b_s1;
    logic                 mask_s1;

    assign q_e = {{2{q[COORD_W-1]}}, q};
    assign r_e = {{2{r[COORD_W-1]}}, r};
    assign a_d = pointy_s0 ? (q_e <<< 1) + r_e : (r_e <<< 1) + q_e;
    assign b_d = pointy_s0 ? r_e : q_e;

    // Stage 1 register: combined axial terms and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1    <= '0;
            b_s1    <= '0;
            mask_s1 <= 1'b0;
        end else if (adv) begin
            a_s1    <= a_d;
            b_s1    <= b_d;
            mask_s1 <= mask;
        end
    end

    // ---------------- stage 2: lattice scale ----------------
    logic signed [PW-1:0] a_e, b_e, ka_e, kb_e, size_e;
    logic signed [PW-1:0] along_a, along_b, hx_s2, hy_s2;
    logic                 mask_s2;

    assign a_e    = {{(PW-AW){a_s1[AW-1]}}, a_s1};
    assign b_e    = {{(PW-AW){b_s1[AW-1]}}, b_s1};
    assign ka_e   = {{(PW-32){1'b0}}, KA};
    assign kb_e   = {{(PW-32){1'b0}}, KB};
    assign size_e = {{(PW-VAL_W){size_s1[VAL_W-1]}}, size_s1};

    // Single floor shift after the full product keeps rounding at one point.
    assign along_a = (a_e * ka_e * size_e) >>> FRAC;
    assign along_b = (b_e * kb_e * size_e) >>> FRAC;

    // Stage 2 register: hex-space position, axes swapped for flat-top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hx_s2   <= '0;
            hy_s2   <= '0;
            mask_s2 <= 1'b0;
        end else if (adv) begin
            hx_s2   <= pointy_s1 ? along_a : along_b;
            hy_s2   <= pointy_s1 ? along_b : along_a;
            mask_s2 <= mask_s1;
        end
    end

    // ---------------- stage 3: camera, zoom, clamp, cull ----------------
    logic signed [DW-1:0]    dx, dy;
    logic signed [MW-1:0]    dx_e, dy_e, zm_e, sh_x, sh_y;
    logic                    ovf_x, ovf_y;
    logic signed [VAL_W-1:0] x_d, y_d;
    logic [63:0]             lim_w, lim_h;
    logic                    in_view;

    assign dx   = {{(DW-PW){hx_s2[PW-1]}}, hx_s2} - {{(DW-VAL_W){cam_x_s2[VAL_W-1]}}, cam_x_s2};
    assign dy   = {{(DW-PW){hy_s2[PW-1]}}, hy_s2} - {{(DW-VAL_W){cam_y_s2[VAL_W-1]}}, cam_y_s2};
    assign dx_e = {{(MW-DW){dx[DW-1]}}, dx};
    assign dy_e = {{(MW-DW){dy[DW-1]}}, dy};
    assign zm_e = {{(MW-VAL_W){zoom_s2[VAL_W-1]}}, zoom_s2};
    assign sh_x = (dx_e * zm_e) >>> FRAC;
    assign sh_y = (dy_e * zm_e) >>> FRAC;

    // A value fits VAL_W iff every bit from the VAL_W sign bit upward agrees.
    assign ovf_x = ~((&sh_x[MW-1:VAL_W-1]) | ~(|sh_x[MW-1:VAL_W-1]));
    assign ovf_y = ~((&sh_y[MW-1:VAL_W-1]) | ~(|sh_y[MW-1:VAL_W-1]));
    assign x_d   = ovf_x ? (sh_x[MW-1] ? VMIN : VMAX) : sh_x[VAL_W-1:0];
    assign y_d   = ovf_y ? (sh_y[MW-1] ? VMIN : VMAX) : sh_y[VAL_W-1:0];

    // Culling runs on the clamped values; negative values fail the sign test.
    assign lim_w   = 64'(view_w_s2) << FRAC;
    assign lim_h   = 64'(view_h_s2) << FRAC;
    assign in_view = !x_d[VAL_W-1] && (64'(x_d[VAL_W-2:0]) < lim_w) &&
                     !y_d[VAL_W-1] && (64'(y_d[VAL_W-2:0]) < lim_h);

    // Stage 3 register: lane outputs; flags suppressed for empty lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x   <= '0;
            y   <= '0;
            vis <= 1'b0;
            sat <= 1'b0;
        end else if (adv) begin
            x   <= x_d;
            y   <= y_d;
            vis <= mask_s2 & in_view;
            sat <= mask_s2 & (ovf_x | ovf_y);
        end
    end

endmodule

// File: rtl/hex_to_screen_pipe.sv
// Multi-lane pipelined axial-hex to screen transform with valid/ready
// handshake. Owns the stage valids and the configuration that rides with
// each beat; per-lane arithmetic lives in hex_lane_xform.
module hex_to_screen_pipe
    import hexraster_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int COORD_W = 16,
    parameter int VAL_W   = HEX_VAL_W,
    parameter int FRAC    = 16
)(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES-1:0][COORD_W-1:0]    in_q,
    input  logic [LANES-1:0][COORD_W-1:0]    in_r,
    input  logic [LANES-1:0]                 in_mask,
    input  logic                             cfg_pointy,
    input  logic [VAL_W-1:0]                 cfg_size,
    input  logic [VAL_W-1:0]                 cfg_cam_x,
    input  logic [VAL_W-1:0]                 cfg_cam_y,
    input  logic [VAL_W-1:0]                 cfg_zoom,
    input  logic [15:0]                      cfg_view_w,
    input  logic [15:0]                      cfg_view_h,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0][VAL_W-1:0]      out_x,
    output logic [LANES-1:0][VAL_W-1:0]      out_y,
    output logic [LANES-1:0]                 out_vis,
    output logic [LANES-1:0]                 out_sat
);

    localparam int STAGES = 3;

    logic              adv;
    logic [STAGES:1]   vld_pipe;
    hex_cfg_t          cfg_in, cfg_s1, cfg_s2;

    // Whole pipe moves together; only a held output beat stalls it.
    assign adv       = !vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // Pack the live configuration for capture with the accepted beat.
    always_comb begin
        cfg_in.pointy = cfg_pointy;
        cfg_in.size   = cfg_size;
        cfg_in.cam_x  = cfg_cam_x;
        cfg_in.cam_y  = cfg_cam_y;
        cfg_in.zoom   = cfg_zoom;
        cfg_in.view_w = cfg_view_w;
        cfg_in.view_h = cfg_view_h;
    end

    // Stage valids and carried configuration, frozen on stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            cfg_s1   <= '0;
            cfg_s2   <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            cfg_s1   <= cfg_in;
            cfg_s2   <= cfg_s1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hex_lane_xform #(
            .COORD_W (COORD_W),
            .VAL_W   (VAL_W),
            .FRAC    (FRAC)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .adv       (adv),
            .pointy_s0 (cfg_pointy),
            .q         (in_q[g]),
            .r         (in_r[g]),
            .mask      (in_mask[g]),
            .pointy_s1 (cfg_s1.pointy),
            .size_s1   (cfg_s1.size),
            .cam_x_s2  (cfg_s2.cam_x),
            .cam_y_s2  (cfg_s2.cam_y),
            .zoom_s2   (cfg_s2.zoom),
            .view_w_s2 (cfg_s2.view_w),
            .view_h_s2 (cfg_s2.view_h),
            .x         (out_x[g]),
            .y         (out_y[g]),
            .vis       (out_vis[g]),
            .sat       (out_sat[g])
        );
    end

endmodule

// File: tb/tb_hex_to_screen_pipe.sv
// Directed bench for hex_to_screen_pipe with hand-computed expected values.
module tb_hex_to_screen_pipe;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0][15:0]     in_q, in_r;
    logic [3:0]           in_mask;
    logic                 cfg_pointy;
    logic [31:0]          cfg_size, cfg_cam_x, cfg_cam_y, cfg_zoom;
    logic [15:0]          cfg_view_w, cfg_view_h;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0][31:0]     out_x, out_y;
    logic [3:0]           out_vis, out_sat;

    int errors = 0;
    int checks = 0;

    hex_to_screen_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_q       (in_q),
        .in_r       (in_r),
        .in_mask    (in_mask),
        .cfg_pointy (cfg_pointy),
        .cfg_size   (cfg_size),
        .cfg_cam_x  (cfg_cam_x),
        .cfg_cam_y  (cfg_cam_y),
        .cfg_zoom   (cfg_zoom),
        .cfg_view_w (cfg_view_w),
        .cfg_view_h (cfg_view_h),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_vis    (out_vis),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        cfg_pointy = 1'b1;
        cfg_size   = 32'd65536;
        cfg_cam_x  = 32'd0;
        cfg_cam_y  = 32'd0;
        cfg_zoom   = 32'd65536;
        cfg_view_w = 16'd1024;
        cfg_view_h = 16'd1024;
        in_q       = '0;
        in_r       = '0;
        in_mask    = '0;
    endtask

    task automatic set_lane(input int i, input int q, input int r, input logic m);
        in_q[i]    = 16'(q);
        in_r[i]    = 16'(r);
        in_mask[i] = m;
    endtask

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  pat;
        logic [31:0] held;
        logic        prev_stall;
        int          sent, rcv, cyc;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        defaults();
        repeat (2) tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_x0",    out_x[0],       32'd0);
        chk("rst_vis",       32'(out_vis),   32'd0);
        chk("rst_sat",       32'(out_sat),   32'd0);
        reset_n = 1'b1;
        tick();

        // 1. Pointy, three lanes plus a masked lane
        set_lane(0, 1, 0, 1'b1);
        set_lane(1, 0, 1, 1'b1);
        set_lane(2, -1, 1, 1'b1);
        set_lane(3, 0, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t1_lat_early", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_x0", out_x[0], 32'd113512);
        chk("t1_y0", out_y[0], 32'd0);
        chk("t1_x1", out_x[1], 32'd56756);
        chk("t1_y1", out_y[1], 32'd98304);
        chk("t1_x2", out_x[2], 32'(-56756));
        chk("t1_y2", out_y[2], 32'd98304);
        chk("t1_vis", 32'(out_vis), 32'b0011);
        chk("t1_sat", 32'(out_sat), 32'b0000);
        tick();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // 2. Flat beat then pointy beat back to back; cfg changes after acceptance
        defaults();
        set_lane(0, 1, 0, 1'b1);
        cfg_pointy = 1'b0;
        in_valid   = 1'b1;
        tick();
        cfg_pointy = 1'b1;
        tick();
        in_valid   = 1'b0;
        cfg_pointy = 1'b0;
        tick();
        chk("t2_b1_valid", 32'(out_valid), 32'd1);
        chk("t2_b1_x", out_x[0], 32'd98304);
        chk("t2_b1_y", out_y[0], 32'd56756);
        chk("t2_b1_vis", 32'(out_vis), 32'b0001);
        tick();
        chk("t2_b2_valid", 32'(out_valid), 32'd1);
        chk("t2_b2_x", out_x[0], 32'd113512);
        chk("t2_b2_y", out_y[0], 32'd0);
        tick();

        // 5. Camera and zoom
        defaults();
        cfg_cam_x = 32'd65536;
        cfg_zoom  = 32'd131072;
        set_lane(0, 1, 0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("t5_x", out_x[0], 32'd95952);
        chk("t5_y", out_y[0], 32'd0);
        chk("t5_vis", 32'(out_vis), 32'b0001);

        // Viewport edges and floor rounding: 1x1 view, zoom 43691
        defaults();
        cfg_zoom   = 32'd43691;
        cfg_view_w = 16'd1;
        cfg_view_h = 16'd1;
        set_lane(0, 0, 0, 1'b1);
        set_lane(1, 0, 1, 1'b1);
        set_lane(2, 1, 0, 1'b1);
        set_lane(3, -1, 0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("edge_x1", out_x[1], 32'd37837);
        chk("edge_y1", out_y[1], 32'd65536);
        chk("edge_x2", out_x[2], 32'd75675);
        chk("edge_x3_floor", out_x[3], 32'(-75676));
        chk("edge_vis", 32'(out_vis), 32'b0001);

        // 3. Saturation both directions, masked lane reports no saturation
        defaults();
        cfg_zoom = 32'h7FFF0000;
        set_lane(0, 32767, 0, 1'b1);
        set_lane(1, -32768, 0, 1'b1);
        set_lane(2, 32767, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("t3_xmax", out_x[0], 32'h7FFFFFFF);
        chk("t3_y0", out_y[0], 32'd0);
        chk("t3_xmin", out_x[1], 32'h80000000);
        chk("t3_sat", 32'(out_sat), 32'b0011);
        chk("t3_vis", 32'(out_vis), 32'b0000);

        // 4. Backpressure: out_ready 1,0,0,1 repeating, 8 beats
        defaults();
        tick();
        pat        = 4'b1001;
        sent       = 0;
        rcv        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        held       = '0;
        while (rcv < 8 && cyc < 60) begin
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            set_lane(0, sent, 0, 1'b1);
            #1;
            if (prev_stall)
                chk("t4_stable", out_x[0], held);
            if (out_valid && out_ready) begin
                chk("t4_order", out_x[0], 32'(113512 * rcv));
                rcv++;
            end
            prev_stall = out_valid && !out_ready;
            held       = out_x[0];
            if (in_valid && in_ready)
                sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_count", 32'(rcv), 32'd8);
        tick();
        chk("t4_no_dup", 32'(out_valid), 32'd0);

        // 6. Reset with two beats in flight
        defaults();
        set_lane(0, 1, 0, 1'b1);
        in_valid = 1'b1;
        tick();
        set_lane(0, 2, 0, 1'b1);
        tick();
        set_lane(0, 3, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_drop", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        #2;
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            chk("t6_quiet", 32'(out_valid), 32'd0);
        end
        set_lane(0, 3, 0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_new_early", 32'(out_valid), 32'd0);
        tick();
        chk("t6_new_valid", 32'(out_valid), 32'd1);
        chk("t6_new_x", out_x[0], 32'd340536);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_to_screen_pipe.md
Name: hex_to_screen_pipe

Overview:
Pipelined, multi-lane successor to the single-cycle batch hex-to-screen transform. It converts axial hex coordinates (q, r) to screen coordinates in signed fixed point, in both pointy-top and flat-top modes. It adds three things the batch block lacks:
- valid/ready backpressure;
- per-beat configuration that travels with its data;
- output saturation and viewport culling.
It sits between the hex-tile fetch stage and the raster setup stage.

Parameters:
LANES, 4, coordinates processed per beat
COORD_W, 16, signed width of q and r
VAL_W, 32, signed width of every fixed-point value (size, cam, zoom, outputs)
FRAC, 16, fractional bits of all fixed-point values; legal range 8..24

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_q  in  LANES x COORD_W  axial q per lane, signed
in_r  in  LANES x COORD_W  axial r per lane, signed
in_mask  in  LANES  per-lane occupancy
cfg_pointy  in  1  1 = pointy-top, 0 = flat-top
cfg_size  in  VAL_W  hex size, Q(VAL_W-FRAC).FRAC
cfg_cam_x, cfg_cam_y  in  VAL_W  camera origin, fixed point
cfg_zoom  in  VAL_W  zoom, fixed point
cfg_view_w, cfg_view_h  in  16  viewport size in integer pixels
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
out_x, out_y  out  LANES x VAL_W  screen coordinates, fixed point
out_vis  out  LANES  lane occupied and inside viewport
out_sat  out  LANES  x or y saturated in this lane

Behaviour:
- Reset: asynchronous on reset_n low. out_valid, out_x, out_y, out_vis and out_sat reset to 0, as do all stage valids. in_ready is 1 whenever out_valid is 0, so it is 1 during and after reset.
- Pipeline: 3 stages with a single shared advance enable, adv = !out_valid | out_ready. in_ready = adv, and it is combinationally dependent on out_ready.
- Configuration: all cfg_* inputs are sampled on the accepted beat and carried down the pipe with that beat. A configuration change between beats therefore never corrupts in-flight data.
- Latency: 3 cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat per cycle.
- Stall: while out_valid & !out_ready, every stage register holds its value and out_x, out_y, out_vis and out_sat stay stable. Empty bubbles do not collapse; a stall freezes the whole pipe.
- Stage 1, per lane:
  - Pointy mode: a = 2q + r, b = r.
  - Flat mode: a = 2r + q, b = q.
  - Computation is exact, at COORD_W+2 bits.
- Stage 2:
  - Let along_a = (a * K_SQRT3_HALF * cfg_size) >>> FRAC and along_b = (b * K_THREE_HALF * cfg_size) >>> FRAC.
  - Pointy mode: hx = along_a, hy = along_b.
  - Flat mode: hx = along_b, hy = along_a.
- Stage 3: x = ((hx - cam_x) * zoom) >>> FRAC, and likewise for y.
- Rounding: every shift is an arithmetic right shift, i.e. floor.
- Intermediate widths: no intermediate value may wrap. Size every product for its operands; at least 2*VAL_W + COORD_W + 4 bits.
- Saturation: the final x and y clamp to [-2^(VAL_W-1), 2^(VAL_W-1)-1]. out_sat[i] = 1 if either coordinate clamped.
- Culling: out_vis[i] = mask[i] & (0 <= x < view_w<<FRAC) & (0 <= y < view_h<<FRAC). The comparisons use the saturated values.
- Masked-off lanes: they are still computed, but out_vis = 0 and out_sat = 0.
- Reset mid-operation: all in-flight beats are discarded and no partial beat appears after reset_n rises.

Decomposition:
- Package hexraster_pkg holds:
  - constants K_SQRT3_HALF_Q16 = 56756 and K_THREE_HALF_Q16 = 98304;
  - function k_scale(k16, frac), which returns k16 shifted left or right by |frac - 16|;
  - typedef hex_cfg_t, a struct of the pointy, size, cam, zoom and view fields.
- One sub-module, hex_lane_xform, implements one lane's three stages with an external adv enable. The top module instantiates LANES copies and owns the handshake and the carried config register.

Test Plan:
All cases use default parameters with size = 65536, cam = 0 and zoom = 65536 unless stated.
1. Pointy; lane0 (q=1, r=0), lane1 (0,1), lane2 (-1,1); view 1024x1024 -> after 3 cycles:
   - lane0: x = 113512, y = 0, vis = 1;
   - lane1: x = 56756, y = 98304, vis = 1;
   - lane2: x = -56756, vis = 0.
2. Flat; (q=1, r=0) -> x = 98304, y = 56756. Beat 2 flips cfg_pointy to 1; beat 1 is still flat and beat 2 is pointy.
3. Saturation: q = 32767, r = 0, zoom = 0x7FFF0000 -> out_x = 0x7FFFFFFF, out_sat = 1. With q = -32768: out_x = 0x80000000, out_sat = 1.
4. Backpressure: stream 8 beats with out_ready toggling in the pattern 1,0,0,1 -> all 8 beats emerge in order with no loss or duplication, and outputs are stable while stalled.
5. Camera/zoom: cam_x = 65536, zoom = 131072, (q=1, r=0) pointy -> x = (113512 - 65536) * 2 = 95952.
6. Reset mid-stream: pull reset_n low with 2 beats in flight -> out_valid drops immediately. After release, out_valid stays 0 until a new beat has been in the pipe 3 cycles.
